// File: rtl/ctrl_resolve_buffer.sv
// Branch-resolution reorder buffer: hands out CTI IDs at dispatch, accepts out-of-order
// resolutions, and releases resolved entries in allocation order to the predictor update port.
module ctrl_resolve_buffer #(
   parameter int CTI_LOG   = 4,
   parameter int CTI_DEPTH = 16,
   parameter int PC_W      = 32,
   parameter int BTYPE_W   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ctiAllocValid_i,
   output logic [CTI_LOG-1:0] ctiAllocID_o,
   output logic               full_o,
   output logic [CTI_LOG:0]   count_o,
   input  logic               exeCtrlValid_i,
   input  logic [CTI_LOG-1:0] exeCtiID_i,
   input  logic [PC_W-1:0]    exeCtrlPC_i,
   input  logic [PC_W-1:0]    exeCtrlNPC_i,
   input  logic [BTYPE_W-1:0] exeCtrlType_i,
   input  logic               exeCtrlDir_i,
   input  logic               recoverFlag_i,
   input  logic [CTI_LOG-1:0] recoverCtiID_i,
   input  logic               exceptionFlag_i,
   output logic               bpUpdValid_o,
   input  logic               bpUpdReady_i,
   output logic [PC_W-1:0]    bpUpdPC_o,
   output logic [PC_W-1:0]    bpUpdNPC_o,
   output logic [BTYPE_W-1:0] bpUpdType_o,
   output logic               bpUpdDir_o
);

   localparam int PTR_W = CTI_LOG + 1;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [CTI_LOG-1:0] head_idx, tail_idx;
   logic [PTR_W-1:0]   count;
   logic               empty;

   logic [CTI_DEPTH-1:0] alloc_q, resolved_q, dir_q;
   logic [PC_W-1:0]      pc_q   [CTI_DEPTH];
   logic [PC_W-1:0]      npc_q  [CTI_DEPTH];
   logic [BTYPE_W-1:0]   type_q [CTI_DEPTH];

   logic               alloc_fire, res_fire, drain_fire;
   logic [PTR_W-1:0]   keep_raw, keep, rec_tail;
   logic [CTI_DEPTH-1:0] discard;

   assign head_idx = head_q[CTI_LOG-1:0];
   assign tail_idx = tail_q[CTI_LOG-1:0];
   assign empty    = (head_q == tail_q);
   assign full_o   = (head_idx == tail_idx) && (head_q[CTI_LOG] != tail_q[CTI_LOG]);
   assign count    = tail_q - head_q;
   assign count_o  = count;

   assign ctiAllocID_o = tail_idx;

   assign bpUpdValid_o = !empty && resolved_q[head_idx];
   assign bpUpdPC_o    = pc_q[head_idx];
   assign bpUpdNPC_o   = npc_q[head_idx];
   assign bpUpdType_o  = type_q[head_idx];
   assign bpUpdDir_o   = dir_q[head_idx];

   // Recovery keeps head..recoverCtiID_i; clamping to the live count means a stale
   // recovery ID can never grow the buffer.
   always_comb begin
      logic [CTI_LOG-1:0] off;
      keep_raw = {1'b0, CTI_LOG'(recoverCtiID_i - head_idx)} + PTR_W'(1);
      keep     = (keep_raw <= count) ? keep_raw : count;
      rec_tail = head_q + keep;
      discard  = '0;
      for (int i = 0; i < CTI_DEPTH; i++) begin
         off        = CTI_LOG'(i) - head_idx;
         discard[i] = ({1'b0, off} >= keep);
      end
   end

   assign alloc_fire = ctiAllocValid_i && !full_o && !exceptionFlag_i && !recoverFlag_i;
   assign res_fire   = exeCtrlValid_i && alloc_q[exeCtiID_i] && !exceptionFlag_i &&
                       !(recoverFlag_i && discard[exeCtiID_i]);
   assign drain_fire = bpUpdValid_o && bpUpdReady_i && !exceptionFlag_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         alloc_q    <= '0;
         resolved_q <= '0;
         dir_q      <= '0;
         for (int i = 0; i < CTI_DEPTH; i++) begin
            pc_q[i]   <= '0;
            npc_q[i]  <= '0;
            type_q[i] <= '0;
         end
      end else if (exceptionFlag_i) begin
         head_q     <= tail_q;
         alloc_q    <= '0;
         resolved_q <= '0;
      end else begin
         if (recoverFlag_i) begin
            tail_q <= rec_tail;
         end else if (alloc_fire) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (drain_fire) begin
            head_q <= head_q + PTR_W'(1);
         end

         if (recoverFlag_i) begin
            alloc_q    <= alloc_q & ~discard;
            resolved_q <= resolved_q & ~discard;
         end
         if (alloc_fire) begin
            alloc_q[tail_idx]    <= 1'b1;
            resolved_q[tail_idx] <= 1'b0;
         end
         if (res_fire) begin
            resolved_q[exeCtiID_i] <= 1'b1;
            pc_q[exeCtiID_i]       <= exeCtrlPC_i;
            npc_q[exeCtiID_i]      <= exeCtrlNPC_i;
            type_q[exeCtiID_i]     <= exeCtrlType_i;
            dir_q[exeCtiID_i]      <= exeCtrlDir_i;
         end
         // Drain clears last so the departing head never survives a same-cycle write.
         if (drain_fire) begin
            alloc_q[head_idx]    <= 1'b0;
            resolved_q[head_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_resolve_buffer.sv
// Directed bench for ctrl_resolve_buffer: a vector table for the out-of-order drain
// plus hand sequences for fill, backpressure, recovery, wrap, exception and async reset.
module tb_ctrl_resolve_buffer;

   logic        clk;
   logic        reset;
   logic        alloc_valid;
   logic [3:0]  alloc_id;
   logic        full;
   logic [4:0]  count;
   logic        exe_valid;
   logic [3:0]  exe_id;
   logic [31:0] exe_pc;
   logic [31:0] exe_npc;
   logic [1:0]  exe_type;
   logic        exe_dir;
   logic        recover;
   logic [3:0]  recover_id;
   logic        exception;
   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_pc;
   logic [31:0] upd_npc;
   logic [1:0]  upd_type;
   logic        upd_dir;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   ctrl_resolve_buffer dut (
      .clk             (clk),
      .reset           (reset),
      .ctiAllocValid_i (alloc_valid),
      .ctiAllocID_o    (alloc_id),
      .full_o          (full),
      .count_o         (count),
      .exeCtrlValid_i  (exe_valid),
      .exeCtiID_i      (exe_id),
      .exeCtrlPC_i     (exe_pc),
      .exeCtrlNPC_i    (exe_npc),
      .exeCtrlType_i   (exe_type),
      .exeCtrlDir_i    (exe_dir),
      .recoverFlag_i   (recover),
      .recoverCtiID_i  (recover_id),
      .exceptionFlag_i (exception),
      .bpUpdValid_o    (upd_valid),
      .bpUpdReady_i    (upd_ready),
      .bpUpdPC_o       (upd_pc),
      .bpUpdNPC_o      (upd_npc),
      .bpUpdType_o     (upd_type),
      .bpUpdDir_o      (upd_dir)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Bench-side encoding of the side fields carried with each resolution.
   function automatic logic [31:0] pc_of(input logic [31:0] npc);
      return npc ^ 32'h1000_0000;
   endfunction

   // driver tasks
   task automatic idle();
      alloc_valid = 1'b0;
      exe_valid   = 1'b0;
      exe_id      = '0;
      exe_pc      = '0;
      exe_npc     = '0;
      exe_type    = '0;
      exe_dir     = 1'b0;
      recover     = 1'b0;
      recover_id  = '0;
      exception   = 1'b0;
      upd_ready   = 1'b0;
   endtask

   task automatic resolve(input logic [3:0] id, input logic [31:0] npc);
      exe_valid = 1'b1;
      exe_id    = id;
      exe_npc   = npc;
      exe_pc    = pc_of(npc);
      exe_type  = npc[10:9];
      exe_dir   = npc[8];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string name, input logic [31:0] npc);
      check({name, "_valid"}, upd_valid, 1);
      check({name, "_npc"}, upd_npc, npc);
      check({name, "_pc"}, upd_pc, pc_of(npc));
      check({name, "_type"}, upd_type, npc[10:9]);
      check({name, "_dir"}, upd_dir, npc[8]);
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_valid"}, upd_valid, 0);
      check({name, "_count"}, count, 0);
      check({name, "_full"}, full, 0);
      check({name, "_id"}, alloc_id, 0);
      check({name, "_npc"}, upd_npc, 0);
      check({name, "_pc"}, upd_pc, 0);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      #1;
      check_reset_state("reset");
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   typedef struct {
      logic        alloc;
      logic        rv;
      logic [3:0]  rid;
      logic [31:0] rnpc;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_npc;
      logic [4:0]  exp_count;
      logic [3:0]  exp_id;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int pops;
      reset = 1'b0;
      idle();

      // out-of-order resolution, in-order drain
      vecs[0] = '{1, 0, 0, 0,        0, 0, 0,        1, 1};
      vecs[1] = '{1, 0, 0, 0,        0, 0, 0,        2, 2};
      vecs[2] = '{1, 0, 0, 0,        0, 0, 0,        3, 3};
      vecs[3] = '{0, 1, 2, 32'h100,  0, 0, 0,        3, 3};
      vecs[4] = '{0, 1, 1, 32'h200,  0, 0, 0,        3, 3};
      vecs[5] = '{0, 1, 0, 32'h300,  0, 1, 32'h300,  3, 3};
      vecs[6] = '{0, 0, 0, 0,        1, 1, 32'h200,  2, 3};
      vecs[7] = '{0, 0, 0, 0,        1, 1, 32'h100,  1, 3};
      vecs[8] = '{0, 0, 0, 0,        1, 0, 0,        0, 3};

      #12;
      do_reset();
      for (int v = 0; v < 9; v++) begin
         idle();
         alloc_valid = vecs[v].alloc;
         upd_ready   = vecs[v].ready;
         if (vecs[v].rv) resolve(vecs[v].rid, vecs[v].rnpc);
         tick();
         check($sformatf("ooo%0d_valid", v), upd_valid, vecs[v].exp_valid);
         check($sformatf("ooo%0d_count", v), count, vecs[v].exp_count);
         check($sformatf("ooo%0d_id", v), alloc_id, vecs[v].exp_id);
         if (vecs[v].exp_valid) check($sformatf("ooo%0d_npc", v), upd_npc, vecs[v].exp_npc);
      end

      // fill to 16, then one dropped request
      do_reset();
      for (int i = 0; i < 16; i++) begin
         idle();
         alloc_valid = 1'b1;
         check($sformatf("fill_id%0d", i), alloc_id, i);
         check($sformatf("fill_full%0d", i), full, 0);
         tick();
         check($sformatf("fill_valid%0d", i), upd_valid, 0);
      end
      check("fill_full", full, 1);
      check("fill_count", count, 16);
      tick();
      check("fill_drop_count", count, 16);
      check("fill_drop_full", full, 1);
      check("fill_drop_id", alloc_id, 0);
      check("fill_drop_valid", upd_valid, 0);

      // backpressure
      do_reset();
      alloc_valid = 1'b1;
      tick();
      idle();
      resolve(0, 32'h555);
      tick();
      idle();
      for (int i = 0; i < 5; i++) begin
         tick();
         check_head($sformatf("bp_hold%0d", i), 32'h555);
         check($sformatf("bp_hold%0d_count", i), count, 1);
      end
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
      check("bp_pop_count", count, 0);
      check("bp_pop_valid", upd_valid, 0);

      // recovery: tail 8 -> keep IDs 0..3
      do_reset();
      alloc_valid = 1'b1;
      repeat (8) tick();
      check("rec_pre_count", count, 8);
      for (int i = 0; i < 3; i++) begin
         idle();
         resolve(4'(i), 32'h10 + 32'(i));
         tick();
      end
      idle();
      recover     = 1'b1;
      recover_id  = 4'd3;
      alloc_valid = 1'b1;
      resolve(3, 32'h33);
      tick();
      check("rec_count", count, 4);
      check("rec_id", alloc_id, 4);
      check_head("rec_head", 32'h10);
      idle();
      resolve(6, 32'h66);
      tick();
      check("rec_stale_count", count, 4);
      idle();
      upd_ready = 1'b1;
      exp_q = '{32'h10, 32'h11, 32'h12, 32'h33};
      for (int i = 0; i < 4; i++) begin
         check_head($sformatf("rec_drain%0d", i), exp_q.pop_front());
         tick();
      end
      check("rec_end_count", count, 0);
      check("rec_end_valid", upd_valid, 0);

      // wrap-around streaming
      do_reset();
      pops = 0;
      for (int k = 0; k < 44; k++) begin
         idle();
         upd_ready   = 1'b1;
         alloc_valid = (k < 40);
         if (k > 0 && k <= 40) begin
            resolve(4'((k - 1) % 16), 32'h1000 + 32'(k - 1));
            exp_q.push_back(32'h1000 + 32'(k - 1));
         end
         if (upd_valid) begin
            if (exp_q.size() == 0) check("wrap_extra_pop", upd_npc, 32'hdead);
            else check($sformatf("wrap_npc%0d", pops), upd_npc, exp_q.pop_front());
            pops++;
         end
         tick();
         check($sformatf("wrap_full%0d", k), full, 0);
         check($sformatf("wrap_count_le16_%0d", k), (count <= 16), 1);
      end
      check("wrap_pops", pops, 40);
      check("wrap_end_count", count, 0);

      // exception flush with same-cycle alloc/resolve/drain requests
      do_reset();
      alloc_valid = 1'b1;
      repeat (5) tick();
      idle();
      resolve(0, 32'h77);
      tick();
      check_head("exc_pre", 32'h77);
      idle();
      exception   = 1'b1;
      alloc_valid = 1'b1;
      upd_ready   = 1'b1;
      resolve(1, 32'h88);
      tick();
      check("exc_count", count, 0);
      check("exc_valid", upd_valid, 0);
      check("exc_id", alloc_id, 5);
      idle();
      resolve(1, 32'h99);
      tick();
      check("exc_post_count", count, 0);
      check("exc_post_valid", upd_valid, 0);

      // asynchronous reset mid-drain
      do_reset();
      alloc_valid = 1'b1;
      repeat (2) tick();
      idle();
      resolve(0, 32'hA0);
      tick();
      resolve(1, 32'hA1);
      tick();
      idle();
      upd_ready = 1'b1;
      tick();
      check_head("areset_pre", 32'hA1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("areset");
      #3;
      idle();
      reset = 1'b1;
      alloc_valid = 1'b1;
      tick();
      check("areset_fresh_count", count, 1);
      check("areset_fresh_id", alloc_id, 1);
      check("areset_fresh_valid", upd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_resolve_buffer.md
Name: ctrl_resolve_buffer

Overview:
Receiving end of the control execution pipe's branch-resolution interface (exeCtrl* signals).
- Allocates a CTI ID to each control instruction at dispatch.
- Captures resolutions, which arrive out of order, indexed by CTI ID.
- Releases resolved entries strictly in allocation order to the branch-predictor/BTB update port through a valid/ready handshake.
- Sits between the control execution pipe and the frontend predictor training logic, with recovery and exception flush hooks.

Parameters:
CTI_LOG, 4, log2 of buffer depth; CTI IDs are CTI_LOG bits wide
CTI_DEPTH, 16, number of entries (must equal 2**CTI_LOG)
PC_W, 32, PC width
BTYPE_W, 2, branch type width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
ctiAllocValid_i  in  1  dispatch requests one CTI entry this cycle
ctiAllocID_o  out  CTI_LOG  ID granted to the requester (current tail)
full_o  out  1  no free entry; allocation ignored
count_o  out  CTI_LOG+1  occupied entries, 0..CTI_DEPTH
exeCtrlValid_i  in  1  resolution valid
exeCtiID_i  in  CTI_LOG  ID of the resolving CTI
exeCtrlPC_i  in  PC_W  CTI PC
exeCtrlNPC_i  in  PC_W  resolved next PC
exeCtrlType_i  in  BTYPE_W  branch type
exeCtrlDir_i  in  1  resolved direction (1 = taken)
recoverFlag_i  in  1  misprediction recovery
recoverCtiID_i  in  CTI_LOG  ID of the mispredicted CTI (kept; younger IDs discarded)
exceptionFlag_i  in  1  full flush
bpUpdValid_o  out  1  head entry ready for predictor update
bpUpdReady_i  in  1  predictor accepts update
bpUpdPC_o  out  PC_W  head PC
bpUpdNPC_o  out  PC_W  head NPC
bpUpdType_o  out  BTYPE_W  head type
bpUpdDir_o  out  1  head direction

Behaviour:
State and pointers
- Head and tail pointers are CTI_LOG+1 bits; the MSB is a wrap bit.
- empty = (head == tail).
- full_o = (index bits equal, wrap bits differ).
- count_o = tail - head, modulo 2**(CTI_LOG+1).
- Per entry: alloc bit, resolved bit, PC, NPC, type, dir.

Reset (reset low, asynchronous)
- Head = tail = 0; all alloc and resolved bits cleared.
- Outputs: ctiAllocID_o = 0, full_o = 0, count_o = 0, bpUpdValid_o = 0.
- bpUpd* data outputs are 0 (entry storage also cleared).
- Reset asserted mid-operation discards all entries immediately; the first cycle after reset release behaves as a fresh buffer.

Allocation
- ctiAllocID_o = tail[CTI_LOG-1:0], combinational.
- If ctiAllocValid_i && !full_o: set alloc[tail], clear resolved[tail], tail++ at the clock edge.
- When full_o, the request is dropped with no state change.

Resolution
- If exeCtrlValid_i && alloc[exeCtiID_i]: write PC/NPC/type/dir and set resolved at the edge.
- A resolution for an unallocated ID is ignored.
- A re-resolution of an already resolved ID overwrites its fields.

Drain
- bpUpdValid_o = !empty && resolved[head], combinational; bpUpd* are driven directly from entry[head].
- On bpUpdValid_o && bpUpdReady_i: clear alloc and resolved at head, head++.
- Zero-cycle latency: a resolution written at edge N can drain in cycle N+1.
- An unresolved head blocks all younger resolved entries.
- Outputs hold steady while bpUpdReady_i is low.

Recovery (recoverFlag_i)
- tail <= recoverCtiID_i + 1, wrap bit recomputed so count_o stays no larger than its pre-recovery value.
- Entries strictly between recoverCtiID_i and the old tail have alloc/resolved cleared.
- A same-cycle resolution for a surviving ID is written.
- A same-cycle resolution for a discarded ID is dropped.
- A same-cycle allocation is dropped.
- A same-cycle drain proceeds normally.

Exception (exceptionFlag_i)
- Head <= tail; all alloc/resolved bits cleared.
- Same-cycle allocation, resolution and drain are all dropped.
- Exception has priority over recovery.

Priority per cycle: reset > exception > recovery > {allocation, resolution, drain}.
- Allocation, resolution and drain may all occur in the same cycle on distinct entries.
- Allocation while full and draining the same cycle is still dropped, because full_o is evaluated before the edge.

Test Plan:
- Fill: 16 allocations, no resolves -> IDs 0..15 granted, full_o=1, count_o=16; a 17th request is ignored; bpUpdValid_o=0 throughout.
- Out of order: allocate 0,1,2, then resolve 2, then 1 (NPC 0x100, 0x200) -> bpUpdValid_o stays 0; resolve 0 (NPC 0x300) -> with ready=1, drains NPC 0x300, 0x200, 0x100 on consecutive cycles, count_o reaches 0.
- Backpressure: resolved head, bpUpdReady_i=0 for 5 cycles -> bpUpdValid_o=1 and bpUpdNPC_o stable; ready=1 -> exactly one pop.
- Recovery: head=0, tail=8, recoverFlag_i with recoverCtiID_i=3 -> count_o=4, ctiAllocID_o=4; a later resolve of ID 6 is ignored; a same-cycle resolve of ID 3 is captured and drains.
- Wrap-around: 40 alloc/resolve/drain cycles with ready=1 -> in-order output across the 15->0 boundary; full_o is never falsely set; count_o never exceeds 16.
- Exception and async reset: exception with 5 entries -> count_o=0 next cycle, no drain; reset pulsed low mid-drain without a clock edge -> all outputs go to 0 immediately.
